// File: rtl/gray_cdc_pkg.sv
// Shared definitions for clock-domain-crossing receivers of Gray-coded counters.
//   state_e    : receiver FSM state encoding (StIdle, StPrime, StTrack)
//   K_DEF      : default counter width
//   SYNC_DEF   : default synchronizer depth
//   g2b        : Gray-to-binary decode; operands are zero-extended to GrayMaxW
//   popcount   : number of set bits; operands are zero-extended to GrayMaxW
package gray_cdc_pkg;

  localparam int unsigned K_DEF    = 8;
  localparam int unsigned SYNC_DEF = 2;

  // Widest counter the helper functions support.
  localparam int unsigned GrayMaxW = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StTrack = 2'd2
  } state_e;

  // Zero high bits leave the low bits of the decode untouched, so callers may
  // zero-extend a narrower code and truncate the result back.
  function automatic logic [GrayMaxW-1:0] g2b(input logic [GrayMaxW-1:0] g);
    logic [GrayMaxW-1:0] b;
    b[GrayMaxW-1] = g[GrayMaxW-1];
    for (int i = GrayMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [GrayMaxW-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < GrayMaxW; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/gray_sync_decoder_if.sv
// Bus between a Gray-counter source domain and the gray_sync_decoder receiver.
//   gray_in, load_in : source-domain Gray count and "counter active" flag
//   err_clr          : destination-domain clear of the sticky error
//   bin_out/bin_valid, delta/delta_valid, gray_err, active : decoder results
//   err_cnt          : saturating error count, only with GRAY_SYNC_ERR_CNT_EN
// Modports: master drives the inputs and observes results; slave is the decoder.
interface gray_sync_decoder_if
  import gray_cdc_pkg::*;
#(
  parameter int unsigned K = K_DEF
);

  logic [K-1:0] gray_in;
  logic         load_in;
  logic         err_clr;
  logic [K-1:0] bin_out;
  logic         bin_valid;
  logic [K-1:0] delta;
  logic         delta_valid;
  logic         gray_err;
  logic         active;
`ifdef GRAY_SYNC_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  modport master (
`ifdef GRAY_SYNC_ERR_CNT_EN
    input  err_cnt,
`endif
    output gray_in, load_in, err_clr,
    input  bin_out, bin_valid, delta, delta_valid, gray_err, active
  );

  modport slave (
`ifdef GRAY_SYNC_ERR_CNT_EN
    output err_cnt,
`endif
    input  gray_in, load_in, err_clr,
    output bin_out, bin_valid, delta, delta_valid, gray_err, active
  );

endinterface

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchronizer: Width bits through Stages back-to-back flops with no
// logic in between. Asynchronous active-high reset clears every stage.
//   clk, rst : destination clock and reset
//   d_i      : asynchronous input
//   q_o      : synchronized output (last stage)
module cdc_sync_bus #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/gray_sync_decoder.sv
// Receive end of a Gray-coded counter CDC path. Synchronizes the Gray bus and
// load flag, decodes to binary, reports the increment per update and flags any
// sample whose code moved by more than one bit (sticky gray_err).
//   clk, rst : destination clock, asynchronous active-high reset
//   bus      : gray_sync_decoder_if.slave (inputs gray_in/load_in/err_clr,
//              outputs bin_out/bin_valid/delta/delta_valid/gray_err/active)
// Optional: define GRAY_SYNC_ERR_CNT_EN to add bus.err_cnt, an 8-bit saturating
// count of multi-bit-change cycles, cleared by rst or err_clr.
// K must not exceed gray_cdc_pkg::GrayMaxW.
module gray_sync_decoder
  import gray_cdc_pkg::*;
#(
  parameter int unsigned K           = K_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_DEF
) (
  input logic                 clk,
  input logic                 rst,
  gray_sync_decoder_if.slave  bus
);

  logic [K-1:0] s;
  logic         ld;

  cdc_sync_bus #(
    .Width  (K),
    .Stages (SYNC_STAGES)
  ) u_sync_gray (
    .clk (clk),
    .rst (rst),
    .d_i (bus.gray_in),
    .q_o (s)
  );

  cdc_sync_bus #(
    .Width  (1),
    .Stages (SYNC_STAGES)
  ) u_sync_load (
    .clk (clk),
    .rst (rst),
    .d_i (bus.load_in),
    .q_o (ld)
  );

  state_e       state_q;
  logic [K-1:0] s_prev_q;
  logic [K-1:0] bin_out_q;
  logic [K-1:0] delta_q;
  logic         bin_valid_q;
  logic         delta_valid_q;
  logic         gray_err_q;
  logic         active_q;

  logic [K-1:0] s_bin;
  logic         changed;
  logic         multi_bit;
  logic         err_hit;

  always_comb begin
    s_bin     = K'(g2b(GrayMaxW'(s)));
    changed   = (s != s_prev_q);
    multi_bit = (popcount(GrayMaxW'(s ^ s_prev_q)) > 1);
    // Errors only count where an update actually happens.
    err_hit   = (state_q == StTrack) && ld && multi_bit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      s_prev_q      <= '0;
      bin_out_q     <= '0;
      delta_q       <= '0;
      bin_valid_q   <= 1'b0;
      delta_valid_q <= 1'b0;
      gray_err_q    <= 1'b0;
      active_q      <= 1'b0;
    end else begin
      delta_valid_q <= 1'b0;
      // A new error beats a same-cycle clear.
      gray_err_q    <= err_hit | (gray_err_q & ~bus.err_clr);
      case (state_q)
        StIdle: begin
          bin_valid_q <= 1'b0;
          active_q    <= 1'b0;
          if (ld) begin
            state_q <= StPrime;
          end
        end
        StPrime: begin
          bin_out_q   <= s_bin;
          s_prev_q    <= s;
          bin_valid_q <= 1'b1;
          state_q     <= StTrack;
        end
        StTrack: begin
          if (!ld) begin
            state_q     <= StIdle;
            bin_valid_q <= 1'b0;
            active_q    <= 1'b0;
          end else begin
            active_q <= 1'b1;
            if (changed) begin
              bin_out_q     <= s_bin;
              delta_q       <= s_bin - bin_out_q;
              delta_valid_q <= 1'b1;
              s_prev_q      <= s;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.bin_out     = bin_out_q;
  assign bus.bin_valid   = bin_valid_q;
  assign bus.delta       = delta_q;
  assign bus.delta_valid = delta_valid_q;
  assign bus.gray_err    = gray_err_q;
  assign bus.active      = active_q;

`ifdef GRAY_SYNC_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else if (bus.err_clr) begin
      err_cnt_q <= err_hit ? 8'd1 : 8'd0;
    end else if (err_hit && (err_cnt_q != 8'hff)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

endmodule
